// File: rtl/vec_wb_collect.sv
// Result-collection stage behind the vector functional units: buffers masked-on
// elements, tracks per-element resolved flags for chaining, and captures scalar results.
module vec_wb_collect #(
  parameter int DATA_WIDTH = 32,
  parameter int MVL        = 16,
  parameter int ID         = 0,
  localparam int IDX_W     = $clog2(MVL),
  localparam int VLR_W     = $clog2(MVL) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  scalar,
  input  logic [VLR_W-1:0]      VLR,
  input  logic [DATA_WIDTH+1:0] in_elem,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH:0]   rd_data,
  output logic [DATA_WIDTH:0]   scalar_out,
  output logic [VLR_W-1:0]      elem_count,
  output logic                  busy,
  output logic                  done
);

  // MVL must be a power of two so the element index wraps cleanly onto the buffer.
  if (MVL != (1 << IDX_W) || ID < 0) begin : g_param_check
    $error("vec_wb_collect: MVL must be a power of two and ID non-negative");
  end

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                state;
  logic [VLR_W-1:0]      vlr_reg;
  logic                  scalar_reg;
  logic [MVL-1:0]        resolved;
  logic [DATA_WIDTH-1:0] elem_buf [MVL];

  logic                  in_valid;
  logic                  in_mask;
  logic [DATA_WIDTH-1:0] in_data;
  logic [IDX_W-1:0]      wr_idx;
  logic [VLR_W-1:0]      next_count;
  logic [VLR_W-1:0]      vlr_clamped;

  assign in_valid    = in_elem[DATA_WIDTH+1];
  assign in_mask     = in_elem[DATA_WIDTH];
  assign in_data     = in_elem[DATA_WIDTH-1:0];
  assign wr_idx      = elem_count[IDX_W-1:0];
  assign next_count  = elem_count + 1'b1;
  // Lengths beyond MVL would walk off the buffer, so they collapse to a full vector.
  assign vlr_clamped = (VLR > VLR_W'(MVL)) ? VLR_W'(MVL) : VLR;

  assign busy    = (state == COLLECT);
  assign rd_data = {resolved[rd_idx], elem_buf[rd_idx]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      vlr_reg    <= '0;
      scalar_reg <= 1'b0;
      resolved   <= '0;
      elem_count <= '0;
      scalar_out <= '0;
      done       <= 1'b0;
      for (int i = 0; i < MVL; i++) elem_buf[i] <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        vlr_reg    <= vlr_clamped;
        scalar_reg <= scalar;
        resolved   <= '0;
        elem_count <= '0;
        scalar_out <= '0;
        if (vlr_clamped == '0) begin
          state <= IDLE;
          done  <= 1'b1;
        end else begin
          state <= COLLECT;
        end
      end else if (state == COLLECT && in_valid) begin
        if (scalar_reg) begin
          scalar_out <= {1'b1, in_data};
          elem_count <= VLR_W'(1);
          state      <= IDLE;
          done       <= 1'b1;
        end else begin
          // Masked-off elements resolve without disturbing the old buffer value.
          if (in_mask) elem_buf[wr_idx] <= in_data;
          resolved[wr_idx] <= 1'b1;
          elem_count       <= next_count;
          if (next_count == vlr_reg) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_wb_collect.sv
// Directed self-checking bench for vec_wb_collect: reset, vector, mask/stall,
// scalar, zero-length and abort scenarios with hand-computed expectations.
module tb_vec_wb_collect;

  localparam int DW    = 32;
  localparam int MVL   = 16;
  localparam int IDX_W = 4;
  localparam int VLR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              scalar;
  logic [VLR_W-1:0]  vlr;
  logic [DW+1:0]     in_elem;
  logic [IDX_W-1:0]  rd_idx;
  logic [DW:0]       rd_data;
  logic [DW:0]       scalar_out;
  logic [VLR_W-1:0]  elem_count;
  logic              busy;
  logic              done;

  int vectors     = 0;
  int miscompares = 0;
  int done_count  = 0;
  int done_mark;

  always #5 clk = ~clk;

  always @(negedge clk) if (rst && done) done_count++;

  vec_wb_collect #(.DATA_WIDTH(DW), .MVL(MVL), .ID(0)) dut (
    .clk(clk), .rst(rst), .start(start), .scalar(scalar), .VLR(vlr),
    .in_elem(in_elem), .rd_idx(rd_idx), .rd_data(rd_data),
    .scalar_out(scalar_out), .elem_count(elem_count), .busy(busy), .done(done)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sc, input logic [VLR_W-1:0] len,
                               input logic v, input logic m, input logic [DW-1:0] d);
    start   = st;
    scalar  = sc;
    vlr     = len;
    in_elem = {v, m, d};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rd(input int idx, input logic [DW:0] exp, input string tag);
    rd_idx = IDX_W'(idx);
    #1;
    checkOutput(tag, 64'(rd_data), 64'(exp));
  endtask

  task automatic check_zero_outputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_count"}, 64'(elem_count), 64'd0);
    checkOutput({tag, "_scalar"}, 64'(scalar_out), 64'd0);
    for (int i = 0; i < MVL; i++) check_rd(i, '0, {tag, "_rd"});
  endtask

  // Feed one vector element and check the count and that done stays low unless last.
  task automatic feed(input logic m, input logic [DW-1:0] d, input int exp_cnt, input logic last);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, m, d);
    step();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("feed_count", 64'(elem_count), 64'(exp_cnt));
    checkOutput("feed_done", 64'(done), 64'(last));
    checkOutput("feed_busy", 64'(busy), 64'(!last));
  endtask

  initial begin
    rst    = 1'b0;
    rd_idx = '0;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    #3;
    check_zero_outputs("reset");
    step();
    rst = 1'b1;
    step();
    checkOutput("post_reset_busy", 64'(busy), 64'd0);

    // Vector, all masked on.
    applyStimulus(1'b1, 1'b0, 5'd4, 1'b0, 1'b0, '0);
    step();
    checkOutput("v4_start_busy", 64'(busy), 64'd1);
    checkOutput("v4_start_count", 64'(elem_count), 64'd0);
    feed(1'b1, 32'h11, 1, 1'b0);
    feed(1'b1, 32'h22, 2, 1'b0);
    feed(1'b1, 32'h33, 3, 1'b0);
    feed(1'b1, 32'h44, 4, 1'b1);
    step();
    checkOutput("v4_done_pulse", 64'(done), 64'd0);
    checkOutput("v4_count_hold", 64'(elem_count), 64'd4);
    check_rd(0, {1'b1, 32'h11}, "v4_rd0");
    check_rd(1, {1'b1, 32'h22}, "v4_rd1");
    check_rd(2, {1'b1, 32'h33}, "v4_rd2");
    check_rd(3, {1'b1, 32'h44}, "v4_rd3");
    check_rd(4, '0, "v4_rd4");

    // Preload buf[1]=0xAA, leaving buf[0]=0x11 via a masked-off element.
    applyStimulus(1'b1, 1'b0, 5'd2, 1'b0, 1'b0, '0);
    step();
    feed(1'b0, 32'hDEAD, 1, 1'b0);
    feed(1'b1, 32'hAA, 2, 1'b1);
    check_rd(0, {1'b1, 32'h11}, "pre_rd0");

    // Mask + stalls.
    applyStimulus(1'b1, 1'b0, 5'd3, 1'b0, 1'b0, '0);
    step();
    check_rd(1, {1'b0, 32'hAA}, "ms_cleared_rd1");
    feed(1'b1, 32'h5, 1, 1'b0);
    step(); step();
    checkOutput("ms_stall_count", 64'(elem_count), 64'd1);
    checkOutput("ms_stall_busy", 64'(busy), 64'd1);
    feed(1'b0, 32'h6, 2, 1'b0);
    step(); step();
    checkOutput("ms_stall_done", 64'(done), 64'd0);
    feed(1'b1, 32'h7, 3, 1'b1);
    check_rd(0, {1'b1, 32'h5}, "ms_rd0");
    check_rd(1, {1'b1, 32'hAA}, "ms_rd1");
    check_rd(2, {1'b1, 32'h7}, "ms_rd2");
    check_rd(3, {1'b0, 32'h44}, "ms_rd3_persist");

    // Scalar capture.
    applyStimulus(1'b1, 1'b1, 5'd16, 1'b0, 1'b0, '0);
    step();
    checkOutput("sc_busy", 64'(busy), 64'd1);
    checkOutput("sc_out_clear", 64'(scalar_out), 64'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h9);
    step();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("sc_out", 64'(scalar_out), 64'({1'b1, 32'h9}));
    checkOutput("sc_done", 64'(done), 64'd1);
    checkOutput("sc_count", 64'(elem_count), 64'd1);
    checkOutput("sc_busy_end", 64'(busy), 64'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h77);
    step();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("sc_done_once", 64'(done), 64'd0);
    checkOutput("sc_idle_count", 64'(elem_count), 64'd1);
    checkOutput("sc_out_hold", 64'(scalar_out), 64'({1'b1, 32'h9}));
    check_rd(0, {1'b0, 32'h5}, "sc_buf_untouched");

    // Zero-length collection.
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, '0);
    step();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("z_done", 64'(done), 64'd1);
    checkOutput("z_busy", 64'(busy), 64'd0);
    checkOutput("z_scalar_clear", 64'(scalar_out), 64'd0);
    step();
    checkOutput("z_done_end", 64'(done), 64'd0);
    checkOutput("z_busy_end", 64'(busy), 64'd0);
    check_rd(0, {1'b0, 32'h5}, "z_rd0");

    // Abort and restart.
    done_mark = done_count;
    applyStimulus(1'b1, 1'b0, 5'd8, 1'b0, 1'b0, '0);
    step();
    feed(1'b1, 32'hA1, 1, 1'b0);
    feed(1'b1, 32'hA2, 2, 1'b0);
    feed(1'b1, 32'hA3, 3, 1'b0);
    applyStimulus(1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 32'hEE);
    step();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("ab_count", 64'(elem_count), 64'd0);
    checkOutput("ab_busy", 64'(busy), 64'd1);
    checkOutput("ab_done", 64'(done), 64'd0);
    check_rd(0, {1'b0, 32'hA1}, "ab_flag_clear");
    feed(1'b1, 32'hB0, 1, 1'b0);
    feed(1'b1, 32'hB1, 2, 1'b1);
    step();
    checkOutput("ab_done_total", 64'(done_count - done_mark), 64'd1);
    check_rd(0, {1'b1, 32'hB0}, "ab_rd0");
    check_rd(1, {1'b1, 32'hB1}, "ab_rd1");
    check_rd(2, {1'b0, 32'hA3}, "ab_rd2");

    // Reset mid-collection with random inputs.
    done_mark = done_count;
    applyStimulus(1'b1, 1'b0, 5'd8, 1'b0, 1'b0, '0);
    step();
    feed(1'b1, 32'hC0, 1, 1'b0);
    feed(1'b1, 32'hC1, 2, 1'b0);
    applyStimulus(1'($urandom), 1'($urandom), 5'($urandom), 1'b1, 1'($urandom), $urandom);
    rst = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    step();
    applyStimulus(1'($urandom), 1'($urandom), 5'($urandom), 1'b1, 1'($urandom), $urandom);
    step();
    check_zero_outputs("mid_reset_hold");
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    step();
    step();
    checkOutput("mr_busy", 64'(busy), 64'd0);
    checkOutput("mr_no_done", 64'(done_count - done_mark), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vec_wb_collect.md
# vec_wb_collect

Result-collection stage directly downstream of the vector logic/arith functional units. Consumes the per-element `{valid, mask, data}` stream a unit emits after its pipeline. Masked-on elements go into a local MVL-entry element buffer; each element's resolved flag is tracked so later stages can chain on it through a read port. Scalar-result operations (e.g. vcpop) are captured into a dedicated scalar register. Completion is signalled with a one-cycle `done` pulse.

## Interface
- `DATA_WIDTH`, 32, element width
- `MVL`, 16, max vector length (power of two); `IDX_W` = log2(MVL), `VLR_W` = log2(MVL)+1 (5 at MVL=16)
- `ID`, 0, instance number (debug only)

- `clk`  in  1  clock; everything is sampled on the rising edge
- `rst`  in  1  one clock; reset is asynchronous and active-low
- `start`  in  1  begin a new collection; captures `VLR` and `scalar`
- `scalar`  in  1  1 = scalar-result operation (single result expected)
- `VLR`  in  VLR_W  number of elements to collect (0..MVL)
- `in_elem`  in  DATA_WIDTH+2  bit DATA_WIDTH+1 = valid, bit DATA_WIDTH = mask, low bits = data
- `rd_idx`  in  IDX_W  chaining read index
- `rd_data`  out  DATA_WIDTH+1  combinational `{resolved[rd_idx], buf[rd_idx]}`
- `scalar_out`  out  DATA_WIDTH+1  registered `{valid, value}`
- `elem_count`  out  VLR_W  elements accepted in the current collection
- `busy`  out  1  collection in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, COLLECT.
- IDLE:
  - `busy`=0; `in_elem` is ignored.
  - `start` → COLLECT: `elem_count`←0, all `resolved` flags←0, `scalar_out`←0, `VLR`/`scalar` latched.
  - If `VLR`=0 at `start`, stay in IDLE and pulse `done` next cycle; no buffer writes.
- COLLECT, vector mode, on a cycle with `in_elem` valid:
  - Element index = `elem_count`.
  - If mask=1: `buf[idx]`←data.
  - If mask=0: `buf[idx]` keeps its old value (mask-undisturbed).
  - In both cases `resolved[idx]`←1 and `elem_count`+1.
- When the accepted element makes `elem_count`=VLR_reg: → IDLE, `done`=1 for one cycle.
- COLLECT, scalar mode:
  - The first valid `in_elem` (mask bit ignored) sets `scalar_out`←`{1, data}` and `elem_count`←1.
  - FSM → IDLE with a `done` pulse.
- Invalid `in_elem` cycles in COLLECT are stalls: no state change.
- Buffer contents persist across collections; only `resolved` is cleared at `start`.
- `start` has priority over everything:
  - `start` in COLLECT aborts the collection and restarts it (flags cleared, count 0); no `done` for the aborted one.
  - A valid `in_elem` in the same cycle as `start` is ignored.
- `elem_count` never exceeds VLR_reg; valid elements arriving after completion are ignored in IDLE.
- `rd_data` is a pure combinational read. A write in cycle N is visible on `rd_data` from cycle N+1 (no write-through bypass).

## Timing
- Async reset while `rst`=0:
  - FSM=IDLE, `busy`=0, `done`=0, `elem_count`=0, `scalar_out`=0.
  - All `resolved`=0 and all `buf` entries=0, so `rd_data`=0.
- Reset mid-collection discards the collection; no `done`.
- `start` at edge N: `busy`=1 and `elem_count`=0 from N+1.
- Element accepted at edge M:
  - `elem_count`, `resolved` and `buf` update after M.
  - If it is the last element, `busy`=0 and `done`=1 during M+1 only.
- VLR=0: `done`=1 during N+1, `busy` stays 0.
- Throughput: one element per cycle, no backpressure; the upstream unit must not exceed it.
- `scalar_out` holds its value until the next `start` or reset.

## Test plan
- Reset: drive `rst`=0 mid-run with random inputs → all outputs 0, `rd_data`=0 for every `rd_idx`; after release `busy`=0.
- Vector, all masked on: `start` with VLR=4, then valid elements 0x11, 0x22, 0x33, 0x44 back-to-back → `rd_data`(0..3) = `{1,0x11}`..`{1,0x44}`; `done` one cycle after the 4th element; `elem_count`=4; `rd_idx`=4 reads resolved=0.
- Mask + stalls: preload buf[1]=0xAA; VLR=3; elements 0x5 (m=1), 0x6 (m=0), 0x7 (m=1) with two idle cycles between them → buf = {0x5, 0xAA, 0x7}, all resolved; `done` only after the 3rd element.
- Scalar: `scalar`=1, VLR=16, single valid element 0x9 with mask=0 → `scalar_out`=`{1,0x9}`, `done` the next cycle, buffer untouched.
- VLR=0 → `done` at N+1, `busy` never high, no resolved flags set.
- Abort: `start` VLR=8, accept 3 elements, `start` again with VLR=2 in the same cycle as a valid element → that element is dropped, flags cleared; next two elements land at idx 0 and 1; exactly one `done`.
